// File: rtl/float_fixed_pkg.sv
// Shared types and helpers for the float -> fixed converter.
//   state_t : control FSM state codes
//   RND_*   : rounding mode encodings of RND_MODE
//   cls_t   : operand classification codes
//   bias_of / field_of : exponent bias and bit-field extraction helpers
package float_fixed_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_ALIGN  = 3'd2,
    ST_ROUND  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] RND_ZERO    = 2'b00;
  localparam logic [1:0] RND_NEAREST = 2'b01;
  localparam logic [1:0] RND_POS     = 2'b10;
  localparam logic [1:0] RND_NEG     = 2'b11;

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_DENORM = 3'd1,
    CLS_NORMAL = 3'd2,
    CLS_INF    = 3'd3,
    CLS_NAN    = 3'd4
  } cls_t;

  // Exponent bias for an EW-bit exponent field.
  function automatic int unsigned bias_of(input int unsigned ew);
    return (32'd1 << (ew - 32'd1)) - 32'd1;
  endfunction

  // Extract 'width' bits starting at bit 'lsb' of a word.
  function automatic logic [63:0] field_of(input logic [63:0] word,
                                           input int unsigned lsb,
                                           input int unsigned width);
    logic [63:0] mask;
    mask = (width >= 32'd64) ? '1 : ((64'd1 << width) - 64'd1);
    return (word >> lsb) & mask;
  endfunction

endpackage

// File: rtl/float_to_fixed_ctrl_fsm.sv
// Control sequencer for the converter: IDLE -> UNPACK -> ALIGN -> ROUND -> DONE.
//   clk, rst        : clock, synchronous active-high reset
//   start           : start request level (only honoured in IDLE; DONE waits for it to drop)
//   capture_en_c    : load operand/mode registers (combinational)
//   unpack_en_c     : load classification registers (combinational)
//   align_en_c      : load aligned magnitude registers (combinational)
//   round_en_c      : load result/flag registers (combinational)
//   busy            : registered, high in UNPACK/ALIGN/ROUND
//   ack             : registered, high in DONE
module float_to_fixed_ctrl_fsm
  import float_fixed_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic capture_en_c,
  output logic unpack_en_c,
  output logic align_en_c,
  output logic round_en_c,
  output logic busy,
  output logic ack
);

  state_t state;
  state_t state_next;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; DONE is left only once start is released.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_UNPACK;
      ST_UNPACK: state_next = ST_ALIGN;
      ST_ALIGN:  state_next = ST_ROUND;
      ST_ROUND:  state_next = ST_DONE;
      ST_DONE:   if (!start) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Stage enables.
  always_comb begin
    capture_en_c = 1'b0;
    unpack_en_c  = 1'b0;
    align_en_c   = 1'b0;
    round_en_c   = 1'b0;
    case (state)
      ST_IDLE:   capture_en_c = start;
      ST_UNPACK: unpack_en_c  = 1'b1;
      ST_ALIGN:  align_en_c   = 1'b1;
      ST_ROUND:  round_en_c   = 1'b1;
      default:   ;
    endcase
  end

  // Status flags registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      ack  <= 1'b0;
    end else begin
      busy <= (state_next == ST_UNPACK) || (state_next == ST_ALIGN) ||
              (state_next == ST_ROUND);
      ack  <= (state_next == ST_DONE);
    end
  end

endmodule

// File: rtl/float_to_fixed_converter.sv
// IEEE-754 float -> signed fixed-point Q(FXW-FRAC-1).FRAC converter.
//   CLK, RST_FF    : clock, synchronous active-high reset
//   Begin_FSM_FF   : start request level, sampled in IDLE
//   RND_MODE       : 00 toward zero, 01 nearest-even, 10 toward +inf, 11 toward -inf
//   FLOAT_IN       : {sign, exponent, mantissa}
//   FIXED_OUT      : registered result, valid while ACK_FF=1
//   ACK_FF, BUSY   : handshake status
//   OVF, INV, INEXACT : saturation, NaN input, discarded-bits flags
module float_to_fixed_converter
  import float_fixed_pkg::*;
#(
  parameter int unsigned EW   = 8,
  parameter int unsigned MW   = 23,
  parameter int unsigned FXW  = 32,
  parameter int unsigned FRAC = 26
)(
  input  logic              CLK,
  input  logic              RST_FF,
  input  logic              Begin_FSM_FF,
  input  logic [1:0]        RND_MODE,
  input  logic [EW+MW:0]    FLOAT_IN,
  output logic [FXW-1:0]    FIXED_OUT,
  output logic              ACK_FF,
  output logic              BUSY,
  output logic              OVF,
  output logic              INV,
  output logic              INEXACT
);

  localparam int unsigned FW   = EW + MW + 1;
  localparam int unsigned LW   = EW + 2;
  localparam int unsigned BIAS = bias_of(EW);
  localparam int unsigned MAGW = FXW + 1;
  localparam int unsigned WIDE = FXW + MW + 2;
  localparam int unsigned RW   = 2 * MW + 3;

  localparam logic [FXW-1:0] POS_LIM = {1'b0, {(FXW-1){1'b1}}};
  localparam logic [FXW-1:0] NEG_LIM = {1'b1, {(FXW-1){1'b0}}};
  localparam logic [MAGW:0]  POS_MAG = (MAGW+1)'(POS_LIM);
  localparam logic [MAGW:0]  NEG_MAG = (MAGW+1)'(NEG_LIM);

  logic capture_en_c, unpack_en_c, align_en_c, round_en_c;

  float_to_fixed_ctrl_fsm u_fsm (
    .clk          (CLK),
    .rst          (RST_FF),
    .start        (Begin_FSM_FF),
    .capture_en_c (capture_en_c),
    .unpack_en_c  (unpack_en_c),
    .align_en_c   (align_en_c),
    .round_en_c   (round_en_c),
    .busy         (BUSY),
    .ack          (ACK_FF)
  );

  // Capture stage.
  logic [FW-1:0] float_q;
  logic [1:0]    mode_q;

  always_ff @(posedge CLK) begin
    if (RST_FF) begin
      float_q <= '0;
      mode_q  <= RND_ZERO;
    end else if (capture_en_c) begin
      float_q <= FLOAT_IN;
      mode_q  <= RND_MODE;
    end
  end

  // Unpack stage: classify and compute the alignment shift L = FRAC - MW + (E - BIAS).
  logic [EW-1:0]        exp_c;
  logic [MW-1:0]        man_c;
  cls_t                 cls_c, cls_q;
  logic signed [LW-1:0] l_c, l_q;
  logic                 sign_q, man_nz_q;
  logic [MW:0]          sig_q;

  always_comb begin
    exp_c = EW'(field_of(64'(float_q), MW, EW));
    man_c = MW'(field_of(64'(float_q), 32'd0, MW));
    if (exp_c == '0)      cls_c = (man_c == '0) ? CLS_ZERO : CLS_DENORM;
    else if (&exp_c)      cls_c = (man_c == '0) ? CLS_INF  : CLS_NAN;
    else                  cls_c = CLS_NORMAL;
    l_c = {2'b00, exp_c} - LW'(BIAS) + LW'(FRAC) - LW'(MW);
  end

  always_ff @(posedge CLK) begin
    if (RST_FF) begin
      cls_q    <= CLS_ZERO;
      l_q      <= '0;
      sign_q   <= 1'b0;
      man_nz_q <= 1'b0;
      sig_q    <= '0;
    end else if (unpack_en_c) begin
      cls_q    <= cls_c;
      l_q      <= l_c;
      sign_q   <= float_q[FW-1];
      man_nz_q <= |man_c;
      sig_q    <= {1'b1, man_c};
    end
  end

  // Align stage: barrel shift {1,M} into the magnitude with guard/sticky.
  int              l_int;
  logic [WIDE-1:0] lsh;
  logic [RW-1:0]   rsh;
  logic [MAGW-1:0] mag_c, mag_q;
  logic            guard_c, sticky_c, aovf_c;
  logic            guard_q, sticky_q, aovf_q;

  always_comb begin
    l_int    = int'(l_q);
    lsh      = '0;
    rsh      = '0;
    mag_c    = '0;
    guard_c  = 1'b0;
    sticky_c = 1'b0;
    aovf_c   = 1'b0;
    if (l_int >= int'(FXW)) begin
      aovf_c = 1'b1;
    end else if (l_int >= 0) begin
      lsh    = WIDE'(sig_q) << l_int;
      mag_c  = lsh[MAGW-1:0];
      aovf_c = |lsh[WIDE-1:MAGW];
    end else if (l_int < -(int'(MW) + 2)) begin
      // Entirely below the guard position: only the sticky bit survives.
      sticky_c = 1'b1;
    end else begin
      rsh      = {sig_q, {(MW+2){1'b0}}} >> (-l_int);
      mag_c    = MAGW'(rsh[RW-1:MW+2]);
      guard_c  = rsh[MW+1];
      sticky_c = |rsh[MW:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_FF) begin
      mag_q    <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      aovf_q   <= 1'b0;
    end else if (align_en_c) begin
      mag_q    <= mag_c;
      guard_q  <= guard_c;
      sticky_q <= sticky_c;
      aovf_q   <= aovf_c;
    end
  end

  // Round stage: increment, negate, saturate, and force special classes.
  logic           inc_c, sat_c;
  logic [MAGW:0]  mag_r_c;
  logic [FXW-1:0] res_c;
  logic           ovf_c, inv_c, inx_c;

  always_comb begin
    case (mode_q)
      RND_ZERO:    inc_c = 1'b0;
      RND_NEAREST: inc_c = guard_q & (sticky_q | mag_q[0]);
      RND_POS:     inc_c = !sign_q & (guard_q | sticky_q);
      RND_NEG:     inc_c = sign_q & (guard_q | sticky_q);
      default:     inc_c = 1'b0;
    endcase
    mag_r_c = {1'b0, mag_q} + (MAGW+1)'(inc_c);
    // The negative range reaches one further than the positive range.
    sat_c   = aovf_q || (sign_q ? (mag_r_c > NEG_MAG) : (mag_r_c > POS_MAG));
    res_c   = '0;
    ovf_c   = 1'b0;
    inv_c   = 1'b0;
    inx_c   = 1'b0;
    case (cls_q)
      CLS_ZERO:   res_c = '0;
      CLS_DENORM: inx_c = man_nz_q;
      CLS_INF: begin
        res_c = sign_q ? NEG_LIM : POS_LIM;
        ovf_c = 1'b1;
      end
      CLS_NAN: begin
        res_c = POS_LIM;
        inv_c = 1'b1;
      end
      default: begin
        if (sat_c) begin
          res_c = sign_q ? NEG_LIM : POS_LIM;
          ovf_c = 1'b1;
        end else begin
          res_c = sign_q ? FXW'(-mag_r_c) : FXW'(mag_r_c);
          inx_c = guard_q | sticky_q;
        end
      end
    endcase
  end

  // Result registers; flags clear on a new capture, value holds until replaced.
  always_ff @(posedge CLK) begin
    if (RST_FF) begin
      FIXED_OUT <= '0;
      OVF       <= 1'b0;
      INV       <= 1'b0;
      INEXACT   <= 1'b0;
    end else if (capture_en_c) begin
      OVF       <= 1'b0;
      INV       <= 1'b0;
      INEXACT   <= 1'b0;
    end else if (round_en_c) begin
      FIXED_OUT <= res_c;
      OVF       <= ovf_c;
      INV       <= inv_c;
      INEXACT   <= inx_c;
    end
  end

endmodule
